// File: rtl/io_input_ctrl_pkg.sv
// Shared definitions for the memory-mapped input peripheral.
// - RegWidth: width of the load address and load data bus.
// - IoAddr*: full-match addresses of the three readable registers.
// - io_reg_e / decode_addr: maps a load address to the register it selects.
package io_input_ctrl_pkg;

  localparam int unsigned RegWidth = 16;

  localparam logic [RegWidth-1:0] IoAddrSw      = 16'hFFF0;
  localparam logic [RegWidth-1:0] IoAddrKey     = 16'hFFF1;
  localparam logic [RegWidth-1:0] IoAddrKeyEdge = 16'hFFF2;

  typedef enum logic [1:0] {
    RegSw,
    RegKey,
    RegKeyEdge,
    RegNone
  } io_reg_e;

  function automatic io_reg_e decode_addr(input logic [RegWidth-1:0] addr);
    case (addr)
      IoAddrSw:      return RegSw;
      IoAddrKey:     return RegKey;
      IoAddrKeyEdge: return RegKeyEdge;
      default:       return RegNone;
    endcase
  endfunction

endpackage

// File: rtl/io_input_ctrl_if.sv
// Load-side read port between the Memory stage and the input peripheral.
// - rd_en   : Memory stage is executing a load this cycle
// - rd_addr : load address
// - rd_hit  : address decodes to a peripheral register (qualified by rd_en)
// - rd_data : zero-extended read data, 0 when rd_hit is low
// master = Memory stage, slave = peripheral.
interface io_input_ctrl_if;
  import io_input_ctrl_pkg::*;

  logic                rd_en;
  logic [RegWidth-1:0] rd_addr;
  logic                rd_hit;
  logic [RegWidth-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_hit,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_hit,
    output rd_data
  );

endinterface

// File: rtl/io_debounce_bit.sv
// Single-bit synchroniser plus debouncer for an asynchronous board input.
// - clk_i    : core clock
// - rst_ni   : asynchronous active-low reset
// - raw_i    : raw input, asynchronous to clk_i
// - stable_o : debounced level; follows raw_i only after it has differed
//              from the current level for DebounceCycles consecutive cycles
// ResetLevel sets the reset value of both sync flops and of the stable flop,
// so a bit held at its idle level through reset produces no spurious change.
module io_debounce_bit #(
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned CntWidth       = 3,
  parameter logic        ResetLevel     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic [1:0]          sync_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                stable_q, stable_d;

  // Two-flop synchroniser; sync_q[1] is the metastability-safe sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetLevel}};
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count,
  // so a glitch shorter than DebounceCycles never reaches stable_q.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= ResetLevel;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped input peripheral: debounced slide switches and push-buttons
// plus sticky press-event bits, read by the Memory stage through a load port.
// - clk_i       : core clock (pipeline clock)
// - rst_ni      : asynchronous active-low reset
// - sw_i        : raw slide switches, asynchronous
// - key_i       : raw push-buttons, active-low, asynchronous
// - rd_if       : load read port (slave side), combinational same-cycle data
// - key_event_o : OR of all sticky key-press event bits
// Registers: IoAddrSw -> switches, IoAddrKey -> pressed keys,
// IoAddrKeyEdge -> press events, cleared by a load from that address.
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int unsigned SwWidth        = 10,
  parameter int unsigned KeyWidth       = 4,
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned CntWidth       = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SwWidth-1:0]  sw_i,
  input  logic [KeyWidth-1:0] key_i,
  io_input_ctrl_if.slave      rd_if,
  output logic                key_event_o
);

  logic [SwWidth-1:0]  sw_stable;
  logic [KeyWidth-1:0] key_stable;
  logic [KeyWidth-1:0] key_pressed;
  logic [KeyWidth-1:0] pressed_q;
  logic [KeyWidth-1:0] key_edge_q, key_edge_d;
  io_reg_e             rd_sel;
  logic                edge_clear;

  for (genvar i = 0; i < SwWidth; i++) begin : gen_sw
    io_debounce_bit #(
      .DebounceCycles(DebounceCycles),
      .CntWidth      (CntWidth),
      .ResetLevel    (1'b0)
    ) u_sw_db (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .raw_i   (sw_i[i]),
      .stable_o(sw_stable[i])
    );
  end

  // Keys idle high, so they reset to the released level.
  for (genvar i = 0; i < KeyWidth; i++) begin : gen_key
    io_debounce_bit #(
      .DebounceCycles(DebounceCycles),
      .CntWidth      (CntWidth),
      .ResetLevel    (1'b1)
    ) u_key_db (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .raw_i   (key_i[i]),
      .stable_o(key_stable[i])
    );
  end

  assign key_pressed = ~key_stable;

  assign rd_sel     = decode_addr(rd_if.rd_addr);
  assign edge_clear = rd_if.rd_en && (rd_sel == RegKeyEdge);

  // Newly detected presses are OR-ed in after the clear so an event arriving
  // on the same edge as a clearing read is kept for the next read.
  always_comb begin
    key_edge_d = edge_clear ? '0 : key_edge_q;
    key_edge_d = key_edge_d | (key_pressed & ~pressed_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pressed_q  <= '0;
      key_edge_q <= '0;
    end else begin
      pressed_q  <= key_pressed;
      key_edge_q <= key_edge_d;
    end
  end

  assign key_event_o = |key_edge_q;

  // Read mux; the KEYEDGE read returns the pre-clear value.
  always_comb begin
    rd_if.rd_hit  = 1'b0;
    rd_if.rd_data = '0;
    if (rd_if.rd_en) begin
      unique case (rd_sel)
        RegSw: begin
          rd_if.rd_hit  = 1'b1;
          rd_if.rd_data = RegWidth'(sw_stable);
        end
        RegKey: begin
          rd_if.rd_hit  = 1'b1;
          rd_if.rd_data = RegWidth'(key_pressed);
        end
        RegKeyEdge: begin
          rd_if.rd_hit  = 1'b1;
          rd_if.rd_data = RegWidth'(key_edge_q);
        end
        RegNone: begin
          rd_if.rd_hit  = 1'b0;
          rd_if.rd_data = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl. Each step drives inputs just after a rising edge,
// queues the expected read-port/event values, and compares them on the
// falling edge before the next rising edge, so "step n" sees the state left
// by n-1 rising edges since its sequence began.
module tb_io_input_ctrl;
  import io_input_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [9:0] sw;
  logic [3:0] key;
  logic       key_event;

  io_input_ctrl_if rd_if ();

  always #5 clk = ~clk;

  io_input_ctrl #(
    .SwWidth       (10),
    .KeyWidth      (4),
    .DebounceCycles(4),
    .CntWidth      (3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .sw_i       (sw),
    .key_i      (key),
    .rd_if      (rd_if),
    .key_event_o(key_event)
  );

  typedef struct packed {
    logic        hit;
    logic [15:0] data;
    logic        evt;
  } exp_t;

  typedef struct {
    logic [9:0]  sw;
    logic [3:0]  key;
    logic        en;
    logic [15:0] addr;
    logic        hit;
    logic [15:0] data;
    logic        evt;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void add(input logic [9:0] s, input logic [3:0] k, input logic en,
                              input logic [15:0] a, input logic h, input logic [15:0] d,
                              input logic ev);
    vec_t v;
    v.sw = s; v.key = k; v.en = en; v.addr = a; v.hit = h; v.data = d; v.evt = ev;
    vecs.push_back(v);
  endfunction

  task automatic push_exp(input logic h, input logic [15:0] d, input logic ev);
    exp_t e;
    e.hit = h; e.data = d; e.evt = ev;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected value queued", tag);
      return;
    end
    e = exp_q.pop_front();
    if (rd_if.rd_hit === e.hit && rd_if.rd_data === e.data && key_event === e.evt) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got hit=%0b data=%h evt=%0b, expected hit=%0b data=%h evt=%0b",
               tag, rd_if.rd_hit, rd_if.rd_data, key_event, e.hit, e.data, e.evt);
    end
  endtask

  task automatic step(input logic [9:0] s, input logic [3:0] k, input logic en,
                      input logic [15:0] a, input logic h, input logic [15:0] d,
                      input logic ev, input string tag);
    sw            = s;
    key           = k;
    rd_if.rd_en   = en;
    rd_if.rd_addr = a;
    push_exp(h, d, ev);
    @(negedge clk);
    check_out(tag);
    @(posedge clk);
    #1;
  endtask

  // Combinational probe without a clock edge (used while reset is held).
  task automatic probe(input logic en, input logic [15:0] a, input logic h,
                       input logic [15:0] d, input logic ev, input string tag);
    rd_if.rd_en   = en;
    rd_if.rd_addr = a;
    push_exp(h, d, ev);
    #1;
    check_out(tag);
  endtask

  initial begin
    rst_ni        = 1'b0;
    sw            = '0;
    key           = 4'hF;
    rd_if.rd_en   = 1'b0;
    rd_if.rd_addr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Reset state of every register and the decode boundaries.
    step(10'h000, 4'hF, 1'b1, IoAddrSw,      1'b1, 16'h0000, 1'b0, "rst_sw");
    step(10'h000, 4'hF, 1'b1, IoAddrKey,     1'b1, 16'h0000, 1'b0, "rst_key");
    step(10'h000, 4'hF, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0, "rst_keyedge");
    step(10'h000, 4'hF, 1'b1, 16'hFFF3,      1'b0, 16'h0000, 1'b0, "rst_unmapped");
    step(10'h000, 4'hF, 1'b0, IoAddrSw,      1'b0, 16'h0000, 1'b0, "rst_noen");

    // Table: switch latency, short glitch, held key press, non-clearing and
    // clearing KEYEDGE reads, unmapped address, release produces no event.
    for (int i = 1; i <= 8; i++)
      add(10'h2A5, 4'hF, 1'b1, IoAddrSw, 1'b1, (i <= 6) ? 16'h0000 : 16'h02A5, 1'b0);
    for (int i = 1; i <= 3; i++)
      add(10'h000, 4'hF, 1'b1, IoAddrSw, 1'b1, 16'h02A5, 1'b0);
    for (int i = 1; i <= 10; i++)
      add(10'h2A5, 4'hF, 1'b1, IoAddrSw, 1'b1, 16'h02A5, 1'b0);
    for (int i = 1; i <= 20; i++)
      add(10'h2A5, 4'hB, 1'b1, IoAddrKey, 1'b1, (i <= 6) ? 16'h0000 : 16'h0004,
          (i >= 8) ? 1'b1 : 1'b0);
    add(10'h2A5, 4'hB, 1'b0, IoAddrKeyEdge, 1'b0, 16'h0000, 1'b1);
    add(10'h2A5, 4'hB, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0004, 1'b1);
    add(10'h2A5, 4'hB, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0);
    add(10'h2A5, 4'hB, 1'b1, 16'hFFF3,      1'b0, 16'h0000, 1'b0);
    for (int i = 1; i <= 8; i++)
      add(10'h2A5, 4'hF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(10'h2A5, 4'hF, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0);
    add(10'h2A5, 4'hF, 1'b1, IoAddrKey,     1'b1, 16'h0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].sw, vecs[i].key, vecs[i].en, vecs[i].addr, vecs[i].hit, vecs[i].data,
           vecs[i].evt, $sformatf("vec%0d", i));

    // Bouncing KEY[0]: toggling never qualifies, the final hold gives one event.
    for (int i = 0; i < 10; i++)
      step(10'h2A5, (i % 2 == 0) ? 4'hE : 4'hF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0,
           $sformatf("bounce%0d", i));
    for (int i = 1; i <= 10; i++)
      step(10'h2A5, 4'hE, 1'b0, 16'h0000, 1'b0, 16'h0000, (i >= 8) ? 1'b1 : 1'b0,
           $sformatf("bounce_hold%0d", i));
    step(10'h2A5, 4'hE, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0001, 1'b1, "bounce_edge");
    step(10'h2A5, 4'hE, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0, "bounce_edge_again");
    for (int i = 1; i <= 8; i++)
      step(10'h2A5, 4'hF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, $sformatf("rel0_%0d", i));

    // KEY[1] becomes stable on the same edge as a clearing read: set wins.
    for (int i = 1; i <= 6; i++)
      step(10'h2A5, 4'hD, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, $sformatf("race_wait%0d", i));
    step(10'h2A5, 4'hD, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0, "race_read0");
    step(10'h2A5, 4'hD, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0002, 1'b1, "race_read1");
    step(10'h2A5, 4'hD, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0, "race_read2");
    for (int i = 1; i <= 8; i++)
      step(10'h2A5, 4'hF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, $sformatf("rel1_%0d", i));

    // Reset in the middle of an all-keys press discards the pending change.
    for (int i = 1; i <= 3; i++)
      step(10'h2A5, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, $sformatf("pre_rst%0d", i));
    rst_ni = 1'b0;
    probe(1'b1, IoAddrKey,     1'b1, 16'h0000, 1'b0, "in_rst_key");
    probe(1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0, "in_rst_keyedge");
    probe(1'b1, IoAddrSw,      1'b1, 16'h0000, 1'b0, "in_rst_sw");
    rst_ni = 1'b1;
    for (int i = 1; i <= 10; i++)
      step(10'h2A5, 4'h0, 1'b1, IoAddrKey, 1'b1, (i <= 6) ? 16'h0000 : 16'h000F,
           (i >= 8) ? 1'b1 : 1'b0, $sformatf("post_rst%0d", i));
    step(10'h2A5, 4'h0, 1'b1, IoAddrKeyEdge, 1'b1, 16'h000F, 1'b1, "post_rst_edge");
    step(10'h2A5, 4'h0, 1'b1, IoAddrKeyEdge, 1'b1, 16'h0000, 1'b0, "post_rst_edge_again");

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL leftover: got %0d queued expectations, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
